// File: rtl/assoc_cache.sv
// assoc_cache: fully-associative write-through data cache with true-LRU replacement,
// flush, hit/miss statistics and a request/acknowledge backing-RAM port.
module assoc_cache #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ENTRIES = 4,
  parameter int CNT_W = 16,
  localparam int AGE_W = $clog2(ENTRIES)
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              ready,
  output logic              done,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [AGE_W-1:0]  lru_way
);
  localparam logic [1:0] IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2, FILL = 2'd3;
  logic [1:0] state;
  logic [ENTRIES-1:0] valid;
  logic [ADDR_W-1:0] tag [ENTRIES];
  logic [DATA_W-1:0] data [ENTRIES];
  logic [AGE_W-1:0] age [ENTRIES];
  logic [DATA_W-1:0] fill_data;
  logic wr_hit;
  logic hit_any, inv_any, acc, touch_en;
  logic [AGE_W-1:0] hit_idx, inv_idx, victim, touch_way;
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_idx = '0;
    inv_idx = '0;
    lru_way = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (valid[i] && tag[i] == addr) begin
        hit_any = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = AGE_W'(i);
      end
      if (age[i] == AGE_W'(ENTRIES-1)) lru_way = AGE_W'(i);
    end
  end
  assign ready = (state == IDLE) && !flush;
  assign acc = ready && req;
  assign victim = inv_any ? inv_idx : lru_way;
  assign touch_en = (acc && hit_any) || state == FILL;
  assign touch_way = (state == FILL) ? victim : hit_idx;
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state <= IDLE;
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        age[i] <= AGE_W'(i);
        tag[i] <= '0;
        data[i] <= '0;
      end
      done <= 1'b0;
      hit <= 1'b0;
      rdata <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      fill_data <= '0;
      wr_hit <= 1'b0;
    end else begin
      done <= 1'b0;
      if (touch_en)
        for (int i = 0; i < ENTRIES; i++)
          age[i] <= (AGE_W'(i) == touch_way) ? '0 :
                    (age[i] < age[touch_way]) ? age[i] + AGE_W'(1) : age[i];
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) age[i] <= AGE_W'(i);
          end else if (req) begin
            if (hit_any) hit_cnt <= hit_cnt + CNT_W'(hit_cnt != '1);
            else miss_cnt <= miss_cnt + CNT_W'(miss_cnt != '1);
            if (rw) begin
              ram_en <= 1'b1;
              ram_we <= 1'b1;
              ram_addr <= addr;
              ram_wdata <= wdata;
              wr_hit <= hit_any;
              if (hit_any) data[hit_idx] <= wdata;
              state <= WR_THRU;
            end else if (hit_any) begin
              rdata <= data[hit_idx];
              hit <= 1'b1;
              done <= 1'b1;
            end else begin
              ram_en <= 1'b1;
              ram_we <= 1'b0;
              ram_addr <= addr;
              state <= RD_MISS;
            end
          end
        end
        RD_MISS: if (ram_ack) begin
          ram_en <= 1'b0;
          fill_data <= ram_rdata;
          state <= FILL;
        end
        FILL: begin
          valid[victim] <= 1'b1;
          tag[victim] <= ram_addr;
          data[victim] <= fill_data;
          rdata <= fill_data;
          hit <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: if (ram_ack) begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          done <= 1'b1;
          hit <= wr_hit;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
